sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one single-port, registered-output sprite/title ROM (4-bit data, 16-bit address, 1-cycle read latency) among NREQ pixel requesters.
- Typical requesters: VGA background fetch, frog sprite, vehicle sprites, log sprites.
- Requester 0 is the real-time background path and has optional absolute priority. The others are served round-robin, with a starvation guard.
- Sits between the per-layer sprite drawers and the ROM instance in the top-level color mapper.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 16, ROM address width.
- DW, 4, ROM data width.
- HIPRI0, 1, 1 = requester 0 always wins when requesting; 0 = requester 0 joins round-robin.
- MAX_WAIT, 7, cycles a pending low-priority requester may be denied before it is forced to win (applies only when HIPRI0=1).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester read request; held with addr until granted.
- addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- gnt  out  NREQ  combinational one-hot grant; a read is accepted on the edge where req[i]&gnt[i].
- rvalid  out  NREQ  registered one-hot; rvalid[i] high the cycle after requester i's read is accepted.
- rdata  out  DW  read data; valid when any rvalid bit is high (passthrough of rom_data).
- rom_addr  out  AW  drives the ROM read_address; combinational mux of the winner's addr.
- rom_data  in  DW  ROM data_Out (registered inside the ROM).
- busy  out  1  registered; high if any req was denied in the previous cycle.

Behaviour:
- Reset (Reset_n=0, async):
  - rr_ptr=0, all wait counters=0, rvalid=0, busy=0.
  - gnt is combinational: it is 0 while reset is held.
  - rom_addr=0 when no grant.
- Arbitration, per cycle and combinational from req, rr_ptr and wait counters, in this order:
  1. Forced: if HIPRI0=1 and any i>=1 has wait[i]==MAX_WAIT, grant the lowest such i. This overrides requester 0.
  2. Priority: else if HIPRI0=1 and req[0], grant 0.
  3. Round-robin: else grant the first requesting index at or after rr_ptr (modulo NREQ). Candidates are indices >=1 if HIPRI0=1, all indices otherwise.
  4. No request: gnt=0, rom_addr=0.
- At most one gnt bit is ever high; gnt[i] is never high without req[i].
- rr_ptr update: on a round-robin or forced grant to i, rr_ptr <= (i+1) mod NREQ. It wraps from NREQ-1 to 0, or to 1 when HIPRI0=1, so index 0 is skipped. A priority grant to 0 leaves rr_ptr unchanged.
- Wait counters (i>=1):
  - req[i]&~gnt[i]: wait[i] increments, saturating at MAX_WAIT.
  - gnt[i] or ~req[i]: wait[i] clears to 0.
  - Width is clog2(MAX_WAIT+1).
- Latency:
  - Accept edge T: ROM samples rom_addr.
  - Cycle T+1: rvalid[i]=1 and rdata=rom_data.
  - Throughput is one read per cycle; back-to-back grants to the same or different requesters are allowed.
- Requesters may keep req high after a grant to issue the next read. The new addr must be presented in the cycle after acceptance.
- busy <= |(req & ~gnt).
- Reset mid-operation: pending rvalid is cleared immediately and the in-flight read is discarded. After release, arbitration restarts from rr_ptr=0 (1 when HIPRI0=1).
- An X/undriven addr from a non-granted requester must not affect rom_addr.

Test Plan:
- Single requester: req[2]=1, addr=0x1234 for one cycle. gnt=0100 that cycle, rom_addr=0x1234; next cycle rvalid=0100 and rdata equals the ROM word at 0x1234. busy stays 0.
- Round-robin (HIPRI0=0): req=1111 held for 8 cycles. Grant order is 0,1,2,3,0,1,2,3, one per cycle, with rvalid following one cycle behind.
- Priority plus starvation (HIPRI0=1, MAX_WAIT=7): req[0] and req[1] held high. Requester 0 wins cycles 0-6, requester 1 is forced on cycle 7, requester 0 wins again on cycle 8. wait[1] reads 0 after the forced grant.
- Wrap-around (HIPRI0=1): rr_ptr=3, req=1110. Grant goes to 3, then 1 (index 0 skipped), then 2.
- Reset mid-read: assert Reset_n=0 asynchronously in the cycle after an accept. rvalid drops to 0 without waiting for a clock edge, with no spurious rvalid after release. The first grant after release with req=1110 (HIPRI0=1) goes to 1.
- No request: req=0000 for 5 cycles. gnt=0, rvalid=0, rom_addr=0, busy=0 throughout.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-output sprite/tile ROM among NREQ pixel requesters.
// Requester 0 may take absolute priority; the rest rotate, with a starvation guard.
module sprite_rom_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 4,
  parameter int unsigned HIPRI0   = 1,
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic               busy
);

  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned PW = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
  localparam logic [PW:0]   NREQ_EXT = (PW+1)'(NREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_nxt;
  logic [WW-1:0] wait_q [1:NREQ-1];

  logic          win_valid;
  logic          win_pri;
  logic [PW-1:0] win_idx;

  // Winner selection: forced starvation grant, then requester-0 priority, then rotation.
  always_comb begin : p_arb
    logic [PW:0]   js;
    logic [PW-1:0] j;
    win_valid = 1'b0;
    win_pri   = 1'b0;
    win_idx   = '0;
    js        = '0;
    j         = '0;
    if (HIPRI0 != 0) begin
      for (int i = NREQ - 1; i >= 1; i--) begin
        if (req[i] && (wait_q[i] == WAIT_SAT)) begin
          win_valid = 1'b1;
          win_idx   = PW'(i);
        end
      end
      if (!win_valid && req[0]) begin
        win_valid = 1'b1;
        win_pri   = 1'b1;
        win_idx   = '0;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      js = {1'b0, rr_ptr} + (PW+1)'(k);
      if (js >= NREQ_EXT) begin
        js = js - NREQ_EXT;
      end
      j = js[PW-1:0];
      if (!win_valid && req[j] && !((HIPRI0 != 0) && (j == '0))) begin
        win_valid = 1'b1;
        win_idx   = j;
      end
    end
  end

  // Grant is suppressed while reset is held.
  always_comb begin
    gnt = '0;
    if (win_valid && Reset_n) begin
      gnt = NREQ'(1) << win_idx;
    end
  end

  // AND-OR mux so a non-granted requester's address can never leak through.
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      rom_addr = rom_addr | (addr[i*AW +: AW] & {AW{gnt[i]}});
    end
  end

  // Pointer moves past a rotating or forced winner; index 0 is skipped when it has priority.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (win_valid && !win_pri) begin
      if (win_idx == PW'(NREQ - 1)) begin
        rr_ptr_nxt = (HIPRI0 != 0) ? PW'(1) : '0;
      end else begin
        rr_ptr_nxt = win_idx + PW'(1);
      end
    end
  end

  assign rdata = rom_data;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr <= '0;
      rvalid <= '0;
      busy   <= 1'b0;
      for (int i = 1; i < NREQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      rr_ptr <= rr_ptr_nxt;
      rvalid <= gnt;
      busy   <= |(req & ~gnt);
      for (int i = 1; i < NREQ; i++) begin
        if (req[i] && !gnt[i]) begin
          wait_q[i] <= (wait_q[i] == WAIT_SAT) ? wait_q[i] : wait_q[i] + WW'(1);
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (rotating and requester-0 priority)
// share stimulus and are checked every cycle against a behavioural model.
module tb_sprite_rom_arbiter;

  localparam int NREQ     = 4;
  localparam int AW       = 16;
  localparam int DW       = 4;
  localparam int MAX_WAIT = 7;

  logic              Clk;
  logic              Reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;

  logic [NREQ-1:0] gnt_rr, gnt_hp, rvalid_rr, rvalid_hp;
  logic [DW-1:0]   rdata_rr, rdata_hp, rom_data_rr, rom_data_hp;
  logic [AW-1:0]   rom_addr_rr, rom_addr_hp;
  logic            busy_rr, busy_hp;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .HIPRI0(0), .MAX_WAIT(MAX_WAIT)) u_rr (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .addr(addr), .gnt(gnt_rr), .rvalid(rvalid_rr),
    .rdata(rdata_rr), .rom_addr(rom_addr_rr), .rom_data(rom_data_rr), .busy(busy_rr));

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .HIPRI0(1), .MAX_WAIT(MAX_WAIT)) u_hp (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .addr(addr), .gnt(gnt_hp), .rvalid(rvalid_hp),
    .rdata(rdata_hp), .rom_addr(rom_addr_hp), .rom_data(rom_data_hp), .busy(busy_hp));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    return a[3:0] + a[7:4] + a[11:8] + a[15:12];
  endfunction

  // Registered-output ROM, one per instance
  always @(posedge Clk) begin
    rom_data_rr <= rom_fn(rom_addr_rr);
    rom_data_hp <= rom_fn(rom_addr_hp);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // Model state per instance (index 0: rotating, 1: requester-0 priority)
  int          m_ptr  [2];
  int          m_wait [2][NREQ];
  logic [3:0]  m_rv   [2];
  logic        m_busy [2];
  logic [15:0] m_raddr[2];

  function automatic int m_arb(input int h);
    if (h == 1) begin
      for (int i = 1; i < NREQ; i++)
        if (req[i] && m_wait[h][i] == MAX_WAIT) return i;
      if (req[0]) return 0;
    end
    for (int k = 0; k < NREQ; k++) begin
      int j = (m_ptr[h] + k) % NREQ;
      if (!(h == 1 && j == 0) && req[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge Clk) begin : p_cmp
    int w;
    logic [3:0]  eg, g_act, rv_act, rd_act;
    logic [15:0] ea, ra_act;
    logic        b_act;
    for (int h = 0; h < 2; h++) begin
      g_act  = h ? gnt_hp : gnt_rr;
      rv_act = h ? rvalid_hp : rvalid_rr;
      rd_act = h ? rdata_hp : rdata_rr;
      ra_act = h ? rom_addr_hp : rom_addr_rr;
      b_act  = h ? busy_hp : busy_rr;
      if (!Reset_n) begin
        m_ptr[h] = 0;
        for (int i = 0; i < NREQ; i++) m_wait[h][i] = 0;
        m_rv[h] = '0; m_busy[h] = 1'b0; m_raddr[h] = '0;
        chk(h ? "hp_rst_gnt" : "rr_rst_gnt", 32'(g_act), 0);
        chk(h ? "hp_rst_rvalid" : "rr_rst_rvalid", 32'(rv_act), 0);
        chk(h ? "hp_rst_busy" : "rr_rst_busy", 32'(b_act), 0);
        chk(h ? "hp_rst_addr" : "rr_rst_addr", 32'(ra_act), 0);
      end else begin
        w  = m_arb(h);
        eg = (w < 0) ? 4'b0 : 4'(1 << w);
        ea = (w < 0) ? 16'h0 : addr[w*AW +: AW];
        chk(h ? "hp_gnt" : "rr_gnt", 32'(g_act), 32'(eg));
        chk(h ? "hp_rom_addr" : "rr_rom_addr", 32'(ra_act), 32'(ea));
        chk(h ? "hp_rvalid" : "rr_rvalid", 32'(rv_act), 32'(m_rv[h]));
        chk(h ? "hp_busy" : "rr_busy", 32'(b_act), 32'(m_busy[h]));
        if (m_rv[h] != 0) chk(h ? "hp_rdata" : "rr_rdata", 32'(rd_act), 32'(rom_fn(m_raddr[h])));
        m_rv[h]    = eg;
        m_raddr[h] = ea;
        m_busy[h]  = |(req & ~eg);
        for (int i = 1; i < NREQ; i++) begin
          if (req[i] && w != i) m_wait[h][i] = (m_wait[h][i] < MAX_WAIT) ? m_wait[h][i] + 1 : MAX_WAIT;
          else m_wait[h][i] = 0;
        end
        if (w >= 0 && !(h == 1 && w == 0)) begin
          m_ptr[h] = (w + 1) % NREQ;
          if (h == 1 && m_ptr[h] == 0) m_ptr[h] = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    tick(); Reset_n = 1'b0; req = '0;
    tick(); Reset_n = 1'b1;
  endtask

  logic [3:0] rr_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] hp_exp [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
  logic [3:0] wr_exp [3] = '{4'b1000, 4'b0010, 4'b0100};

  initial begin
    Reset_n = 1'b0; req = '0; addr = '0;
    repeat (2) @(negedge Clk);
    req = 4'hF; #1;
    chk("lit_rst_gnt_hp", 32'(gnt_hp), 0);
    chk("lit_rst_gnt_rr", 32'(gnt_rr), 0);
    chk("lit_rst_rvalid", 32'(rvalid_hp), 0);

    // Single requester
    do_reset();
    addr = {$urandom(), $urandom()};
    addr[2*AW +: AW] = 16'h1234;
    req = 4'b0100;
    @(negedge Clk);
    chk("lit_single_gnt", 32'(gnt_hp), 32'h4);
    chk("lit_single_addr", 32'(rom_addr_hp), 32'h1234);
    chk("lit_single_busy0", 32'(busy_hp), 0);
    tick(); req = '0;
    @(negedge Clk);
    chk("lit_single_rvalid", 32'(rvalid_rr), 32'h4);
    chk("lit_single_rdata", 32'(rdata_rr), 32'hA);
    chk("lit_single_busy1", 32'(busy_rr), 0);

    // Round-robin order with all requesting
    do_reset(); req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      chk("lit_rr_order", 32'(gnt_rr), 32'(rr_exp[k]));
      tick();
    end
    req = '0;
    @(negedge Clk);
    chk("lit_rr_rvalid_tail", 32'(rvalid_rr), 32'h8);

    // Priority with starvation guard
    do_reset(); req = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      @(negedge Clk);
      chk("lit_starve_order", 32'(gnt_hp), 32'(hp_exp[k]));
      tick();
    end

    // Wrap-around skipping index 0
    do_reset(); req = 4'b0100;
    @(negedge Clk);
    chk("lit_wrap_pre", 32'(gnt_hp), 32'h4);
    tick(); req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("lit_wrap_order", 32'(gnt_hp), 32'(wr_exp[k]));
      tick();
    end

    // Reset in the cycle after an accept
    do_reset(); req = 4'b0010;
    @(negedge Clk);
    chk("lit_mid_gnt", 32'(gnt_hp), 32'h2);
    tick(); req = '0;
    chk("lit_mid_rvalid_pre", 32'(rvalid_hp), 32'h2);
    #1 Reset_n = 1'b0;
    #1;
    chk("lit_mid_rvalid_async_hp", 32'(rvalid_hp), 0);
    chk("lit_mid_rvalid_async_rr", 32'(rvalid_rr), 0);
    tick(); tick();
    Reset_n = 1'b1; req = 4'b1110;
    @(negedge Clk);
    chk("lit_mid_first_gnt", 32'(gnt_hp), 32'h2);
    chk("lit_mid_no_rvalid", 32'(rvalid_hp), 0);
    tick(); req = '0;

    // Idle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("lit_idle_gnt", 32'(gnt_hp), 0);
      chk("lit_idle_rvalid", 32'(rvalid_hp), 0);
      chk("lit_idle_addr", 32'(rom_addr_hp), 0);
      chk("lit_idle_busy", 32'(busy_hp), 0);
      tick();
    end

    // Random sticky requests with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      addr = {$urandom(), $urandom()};
      Reset_n = ($urandom_range(299) != 0);
      tick();
    end
    Reset_n = 1'b1; req = '0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
